// File: rtl/load_pkg.sv
// Shared definitions for the load unit: funct3 encodings, FSM states,
// XLEN-dependent offset width and access legality helpers.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Number of byte-offset bits inside one aligned XLEN word.
  function automatic int off_width(input int xlen);
    return (xlen == 64) ? 3 : 2;
  endfunction

  // LD and LWU only exist on a 64-bit datapath; encoding 7 never exists.
  function automatic logic funct3_illegal(input logic [2:0] f3, input logic is64);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: funct3_illegal = 1'b0;
      F3_LD, F3_LWU:                       funct3_illegal = !is64;
      default:                             funct3_illegal = 1'b1;
    endcase
  endfunction

  // True when the offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3)
      F3_LH, F3_LHU: misaligned = off[0];
      F3_LW, F3_LWU: misaligned = |off[1:0];
      F3_LD:         misaligned = |off;
      default:       misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane selection and sign/zero extension of a loaded word.
// Lane indices are truncated to the natural alignment of the access size.
module load_align
  import load_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  data,
  output logic [XLEN-1:0]  result
);

  logic [OFF_W-1:0]  off_h;
  logic [OFF_W-1:0]  off_w;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic signed [31:0] lane_w;

  // Pick the byte/half/word lane and extend it according to the load type.
  always_comb begin
    off_h  = off & ~OFF_W'(1);
    off_w  = off & ~OFF_W'(3);
    lane_b = data[{off, 3'b000} +: 8];
    lane_h = data[{off_h, 3'b000} +: 16];
    lane_w = data[{off_w, 3'b000} +: 32];
    case (funct3)
      F3_LB:   result = XLEN'(lane_b);
      F3_LH:   result = XLEN'(lane_h);
      F3_LW:   result = XLEN'(lane_w);
      F3_LBU:  result = XLEN'($unsigned(lane_b));
      F3_LHU:  result = XLEN'($unsigned(lane_h));
      F3_LWU:  result = XLEN'($unsigned(lane_w));
      F3_LD:   result = data;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: computes the effective address, issues one aligned memory read,
// then extracts and extends the addressed lane into rd_value.
// Build option: define LOAD_MISALIGN_TRAP_EN to fault misaligned half/word/
// double accesses instead of truncating the lane index.
module load_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_enable,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_value,
  input  logic [XLEN-1:0]   immediate12_itype,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_address,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [XLEN-1:0]   rd_value
);

  localparam int OFF_W = off_width(XLEN);

  state_t            state;
  logic [2:0]        f3_q;
  logic [OFF_W-1:0]  off_q;
  logic [XLEN-1:0]   sum;
  logic [ADDR_W-1:0] ea_next;
  logic [OFF_W-1:0]  off_next;
  logic              illegal;
  logic [XLEN-1:0]   lane;

  // Effective address (wraps modulo 2^ADDR_W) and legality of the new request.
  always_comb begin
    sum      = rs1_value + immediate12_itype;
    ea_next  = sum[ADDR_W-1:0];
    off_next = ea_next[OFF_W-1:0];
`ifdef LOAD_MISALIGN_TRAP_EN
    illegal  = funct3_illegal(funct3, (XLEN == 64)) || misaligned(funct3, 3'(off_next));
`else
    illegal  = funct3_illegal(funct3, (XLEN == 64));
`endif
  end

  load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_align (
    .funct3 (f3_q),
    .off    (off_q),
    .data   (mem_rsp_data),
    .result (lane)
  );

  // Control FSM with all interface outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      f3_q            <= 3'd0;
      off_q           <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_address <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fault           <= 1'b0;
      rd_value        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          if (load_enable) begin
            f3_q  <= funct3;
            off_q <= off_next;
            busy  <= 1'b1;
            if (illegal) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              fault    <= 1'b1;
              rd_value <= '0;
            end else begin
              state           <= ST_REQ;
              mem_req_valid   <= 1'b1;
              mem_req_address <= {ea_next[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state         <= ST_WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            fault    <= 1'b0;
            rd_value <= lane;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          mem_req_valid <= 1'b0;
          done          <= 1'b0;
          fault         <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit (XLEN=32, ADDR_W=32): directed cases plus
// randomized loads compared against a size/offset arithmetic reference model.
module tb_load_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_enable;
  logic [2:0]  funct3;
  logic [31:0] rs1_value;
  logic [31:0] immediate12_itype;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_address;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rd_value;

  int n_cmp = 0;
  int n_bad = 0;

  load_unit dut (
    .clock             (clock),
    .reset             (reset),
    .load_enable       (load_enable),
    .funct3            (funct3),
    .rs1_value         (rs1_value),
    .immediate12_itype (immediate12_itype),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_address   (mem_req_address),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .busy              (busy),
    .done              (done),
    .fault             (fault),
    .rd_value          (rd_value)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: access size in bytes, lane = aligned-down offset, then
  // arithmetic sign adjustment for the signed loads.
  function automatic void ref_load(input logic [2:0] f3, input logic [31:0] ea,
                                   input logic [31:0] data, output logic flt,
                                   output logic [31:0] addr, output logic [31:0] rd);
    int     size;
    bit     sgn;
    int     off;
    int     lo;
    longint v;
    addr = ea - (ea % 4);
    off  = int'(ea % 4);
    case (f3)
      3'd0:    begin size = 1; sgn = 1'b1; end
      3'd1:    begin size = 2; sgn = 1'b1; end
      3'd2:    begin size = 4; sgn = 1'b1; end
      3'd4:    begin size = 1; sgn = 1'b0; end
      3'd5:    begin size = 2; sgn = 1'b0; end
      default: begin size = 0; sgn = 1'b0; end
    endcase
    flt = 1'b0;
    rd  = 32'h0;
    if (size == 0) begin
      flt = 1'b1;
    end else begin
`ifdef LOAD_MISALIGN_TRAP_EN
      if (off % size != 0) flt = 1'b1;
`endif
      if (!flt) begin
        lo = off - (off % size);
        v  = (longint'({32'h0, data}) >> (8 * lo)) % (64'sd1 << (8 * size));
        if (sgn && v >= (64'sd1 << (8 * size - 1))) v = v - (64'sd1 << (8 * size));
        rd = v[31:0];
      end
    end
  endfunction

  // One complete load; called and returning at a falling edge with the DUT idle.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] data, input int rdy_delay, input int rsp_delay);
    logic        e_flt;
    logic [31:0] e_addr;
    logic [31:0] e_rd;
    ref_load(f3, rs1 + imm, data, e_flt, e_addr, e_rd);
    load_enable       = 1'b1;
    funct3            = f3;
    rs1_value         = rs1;
    immediate12_itype = imm;
    mem_req_ready     = 1'b0;
    mem_rsp_valid     = 1'b0;
    @(negedge clock);
    load_enable = 1'b0;
    if (e_flt) begin
      check_eq("ill_req_valid", mem_req_valid, 1'b0);
      check_eq("ill_done", done, 1'b1);
      check_eq("ill_fault", fault, 1'b1);
      check_eq("ill_rd", rd_value, 32'h0);
    end else begin
      for (int i = 0; i < rdy_delay; i++) begin
        check_eq("req_valid", mem_req_valid, 1'b1);
        check_eq("req_addr", mem_req_address, e_addr);
        check_eq("req_busy", busy, 1'b1);
        load_enable   = 1'($urandom_range(0, 1));
        funct3        = 3'($urandom_range(0, 7));
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_data  = $urandom;
        @(negedge clock);
      end
      check_eq("req_valid", mem_req_valid, 1'b1);
      check_eq("req_addr", mem_req_address, e_addr);
      load_enable   = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clock);
      mem_req_ready = 1'b0;
      for (int i = 0; i < rsp_delay; i++) begin
        check_eq("wait_valid", mem_req_valid, 1'b0);
        check_eq("wait_done", done, 1'b0);
        @(negedge clock);
      end
      check_eq("wait_valid", mem_req_valid, 1'b0);
      check_eq("wait_done", done, 1'b0);
      mem_rsp_data  = data;
      mem_rsp_valid = 1'b1;
      @(negedge clock);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      check_eq("done", done, 1'b1);
      check_eq("fault", fault, 1'b0);
      check_eq("rd_value", rd_value, e_rd);
      check_eq("done_busy", busy, 1'b1);
    end
    // A start in the DONE cycle must be ignored.
    load_enable = 1'b1;
    funct3      = 3'd2;
    @(negedge clock);
    load_enable = 1'b0;
    check_eq("idle_done", done, 1'b0);
    check_eq("idle_fault", fault, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_rd_hold", rd_value, e_rd);
    check_eq("idle_req_valid", mem_req_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    reset             = 1'b1;
    load_enable       = 1'b0;
    funct3            = 3'd0;
    rs1_value         = 32'h0;
    immediate12_itype = 32'h0;
    mem_req_ready     = 1'b0;
    mem_rsp_valid     = 1'b0;
    mem_rsp_data      = 32'h0;
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_fault", fault, 1'b0);
    check_eq("rst_rd", rd_value, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases.
    run_load(3'd0, 32'h0000_0100, 32'h0000_0003, 32'h80FF_0000, 0, 0);
    run_load(3'd5, 32'h0000_0200, 32'h0000_0002, 32'h8001_1234, 0, 0);
    run_load(3'd1, 32'h0000_0200, 32'h0000_0002, 32'h8001_1234, 0, 0);
    run_load(3'd2, 32'h0000_0100, 32'h0000_0000, 32'hCAFE_F00D, 5, 0);
    run_load(3'd7, 32'h0000_0100, 32'h0000_0000, 32'h1234_5678, 0, 0);
    run_load(3'd3, 32'h0000_0100, 32'h0000_0000, 32'h1234_5678, 0, 0);
    run_load(3'd6, 32'h0000_0100, 32'h0000_0000, 32'h1234_5678, 0, 0);
    run_load(3'd2, 32'h0000_0100, 32'h0000_0002, 32'h8765_4321, 1, 2);
    run_load(3'd4, 32'hFFFF_FFFF, 32'h0000_0003, 32'hA5B6_C7D8, 0, 1);
    run_load(3'd1, 32'h0000_0010, 32'hFFFF_FFF1, 32'hF00F_7FFE, 2, 0);

    // Reset while waiting for the response abandons the access.
    load_enable       = 1'b1;
    funct3            = 3'd2;
    rs1_value         = 32'h0000_0300;
    immediate12_itype = 32'h0;
    @(negedge clock);
    load_enable   = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    check_eq("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_req_valid", mem_req_valid, 1'b0);
    @(negedge clock);
    reset         = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1357_9BDF;
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    check_eq("post_rst_done", done, 1'b0);
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_rd", rd_value, 32'h0);
    @(negedge clock);
    check_eq("post_rst_done2", done, 1'b0);
    run_load(3'd2, 32'h0000_0300, 32'h0000_0004, 32'h2468_ACE0, 0, 0);

    // Randomized loads.
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      run_load(3'($urandom_range(0, 7)), $urandom, {{20{r[11]}}, r[11:0]}, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
